// File: rtl/packet_serdes_pkg.sv
// Shared state encoding and default packet width for the packet serializer/deserializer.
package packet_serdes_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REC       = 2'd1,
        PLAY_WAIT = 2'd2,
        PLAY      = 2'd3
    } state_e;

    localparam int PKT_W_DEF = 32;

endpackage

// File: rtl/pkt_bit_counter.sv
// Modulo-PKT_W bit index counter with synchronous clear, enable and a wrap flag
// that is high on the enabled cycle in which the count rolls over.
module pkt_bit_counter
    import packet_serdes_pkg::*;
#(
    parameter int PKT_W = PKT_W_DEF,
    parameter int CNT_W = $clog2(PKT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    assign wrap = en && (count == CNT_W'(PKT_W - 1));

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (en)
            count <= wrap ? '0 : count + CNT_W'(1);
    end

endmodule

// File: rtl/packet_serdes.sv
// Record/playback serializer: packs bit_in into PKT_W-bit words and streams fetched words out MSB first.
// Optional macro PACKET_SERDES_PARTIAL_FLUSH_EN: stop during a partial record word emits it left-aligned.
module packet_serdes
    import packet_serdes_pkg::*;
#(
    parameter int PKT_W = PKT_W_DEF,
    parameter int CNT_W = $clog2(PKT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rec_butt,
    input  logic             play_butt,
    input  logic             stop_butt,
    input  logic             bit_en,
    input  logic             bit_in,
    output logic [PKT_W-1:0] wr_data,
    output logic             wr_valid,
    output logic             rd_req,
    input  logic [PKT_W-1:0] rd_data,
    input  logic             rd_valid,
    output logic             bit_out,
    output logic             bit_out_valid,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       mode
);

    state_e           state, state_nxt;
    logic [PKT_W-1:0] sreg;
    logic             pend;
    logic             any_butt, cnt_en, cnt_clr, wrap, load;

    assign any_butt = stop_butt || rec_butt || play_butt;
    assign cnt_en   = bit_en && !any_butt && (state == REC || state == PLAY);
    assign cnt_clr  = any_butt || state == IDLE || state == PLAY_WAIT;
    // Only the response to the request still outstanding may start playback.
    assign load     = (state == PLAY_WAIT) && rd_valid && pend && !any_butt;

    pkt_bit_counter #(.PKT_W(PKT_W), .CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clr),
        .en    (cnt_en),
        .count (count),
        .wrap  (wrap)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stop_butt)
            state_nxt = IDLE;
        else if (rec_butt)
            state_nxt = REC;
        else if (play_butt)
            state_nxt = PLAY_WAIT;
        else begin
            case (state)
                PLAY_WAIT: if (load) state_nxt = PLAY;
                PLAY:      if (wrap) state_nxt = PLAY_WAIT;
                default:   ;
            endcase
        end
    end

    always_comb begin
        mode          = state;
        bit_out_valid = (state == PLAY);
        bit_out       = (state == PLAY) && sreg[PKT_W-1];
    end

    // One shift register serves both directions: bits enter at the LSB in REC and leave from the MSB in PLAY.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg     <= '0;
            wr_data  <= '0;
            wr_valid <= 1'b0;
            rd_req   <= 1'b0;
            pend     <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            rd_req   <= 1'b0;
            if (stop_butt) begin
`ifdef PACKET_SERDES_PARTIAL_FLUSH_EN
                if (state == REC && count != '0) begin
                    wr_data  <= sreg << (PKT_W - int'(count));
                    wr_valid <= 1'b1;
                end
`endif
                sreg <= '0;
                pend <= 1'b0;
            end else if (rec_butt) begin
                sreg <= '0;
                pend <= 1'b0;
            end else if (play_butt) begin
                sreg   <= '0;
                pend   <= 1'b0;
                rd_req <= 1'b1;
            end else begin
                if (rd_req)
                    pend <= 1'b1;
                else if (load)
                    pend <= 1'b0;
                case (state)
                    REC: if (bit_en) begin
                        if (wrap) begin
                            wr_data  <= {sreg[PKT_W-2:0], bit_in};
                            wr_valid <= 1'b1;
                            sreg     <= '0;
                        end else
                            sreg <= {sreg[PKT_W-2:0], bit_in};
                    end
                    PLAY_WAIT: if (load) sreg <= rd_data;
                    PLAY: if (bit_en) begin
                        sreg <= sreg << 1;
                        if (wrap) rd_req <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_packet_serdes.sv
// Self-checking bench for packet_serdes: vector table, directed corner sequences and a randomized run
// against a queue-based reference model of the record/playback behaviour.
module tb_packet_serdes;

    logic        clk = 1'b0;
    logic        reset, rec_butt, play_butt, stop_butt, bit_en, bit_in, rd_valid;
    logic [31:0] rd_data, wr_data;
    logic        wr_valid, rd_req, bit_out, bit_out_valid;
    logic [4:0]  count;
    logic [1:0]  mode;

    packet_serdes #(.PKT_W(32)) dut (
        .clk(clk), .reset(reset), .rec_butt(rec_butt), .play_butt(play_butt), .stop_butt(stop_butt),
        .bit_en(bit_en), .bit_in(bit_in), .wr_data(wr_data), .wr_valid(wr_valid), .rd_req(rd_req),
        .rd_data(rd_data), .rd_valid(rd_valid), .bit_out(bit_out), .bit_out_valid(bit_out_valid),
        .count(count), .mode(mode)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, wv_seen = 0;

    // Reference model: recorded bits kept in a queue, playback as a word plus bit index.
    int          m_mode = 0, m_pidx = 0;
    bit          m_q[$];
    logic [31:0] m_wr = '0, m_pw = '0;
    bit          m_wv = 0, m_rq = 0, m_pend = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, rb, pb, sb, be, bi, rv, input logic [31:0] d);
        bit old_rq, old_pend;
        logic [31:0] w;
        old_rq = m_rq; old_pend = m_pend;
        m_wv = 0; m_rq = 0;
        if (r) begin
            m_mode = 0; m_q.delete(); m_wr = '0; m_pend = 0; m_pidx = 0; m_pw = '0;
            return;
        end
        if (sb || rb || pb) begin
`ifdef PACKET_SERDES_PARTIAL_FLUSH_EN
            if (sb && m_mode == 1 && m_q.size() > 0) begin
                w = '0;
                foreach (m_q[i]) w[31-i] = m_q[i];
                m_wr = w; m_wv = 1;
            end
`endif
            m_q.delete(); m_pend = 0; m_pidx = 0;
            m_mode = sb ? 0 : (rb ? 1 : 2);
            m_rq = !sb && !rb;
            return;
        end
        case (m_mode)
            1: if (be) begin
                m_q.push_back(bi);
                if (m_q.size() == 32) begin
                    w = '0;
                    foreach (m_q[i]) w[31-i] = m_q[i];
                    m_wr = w; m_wv = 1; m_q.delete();
                end
            end
            2: if (rv && old_pend) begin
                m_pw = d; m_pidx = 0; m_mode = 3; m_pend = 0;
            end
            3: if (be) begin
                m_pidx++;
                if (m_pidx == 32) begin m_pidx = 0; m_mode = 2; m_rq = 1; end
            end
            default: ;
        endcase
        if (old_rq) m_pend = 1;
    endtask

    task automatic cyc(input bit r, rb, pb, sb, be, bi, rv, input logic [31:0] d);
        int ecnt;
        reset = r; rec_butt = rb; play_butt = pb; stop_butt = sb;
        bit_en = be; bit_in = bi; rd_valid = rv; rd_data = d;
        @(posedge clk); #1;
        model_step(r, rb, pb, sb, be, bi, rv, d);
        ecnt = (m_mode == 1) ? m_q.size() : (m_mode == 3) ? m_pidx : 0;
        check("mdl_mode", mode, m_mode);
        check("mdl_count", count, ecnt);
        check("mdl_wr_valid", wr_valid, m_wv);
        check("mdl_wr_data", wr_data, m_wr);
        check("mdl_rd_req", rd_req, m_rq);
        check("mdl_bov", bit_out_valid, m_mode == 3);
        check("mdl_bit_out", bit_out, (m_mode == 3) ? m_pw[31-m_pidx] : 1'b0);
        if (wr_valid) wv_seen++;
    endtask

    task automatic idle(); cyc(0, 0, 0, 0, 0, 0, 0, '0); endtask

    typedef struct {
        bit r, rb, pb, sb, be, bi, rv;
        logic [31:0] d;
        int mode, cnt;
        bit wv, rq, bov;
    } vec_t;

    initial begin
        vec_t tbl[16];
        logic [31:0] w, got, wd_before;
        tbl[0]  = '{1,0,0,0,0,0,0, 32'h0,        0,0,0,0,0};
        tbl[1]  = '{0,0,0,0,1,1,0, 32'h0,        0,0,0,0,0};
        tbl[2]  = '{0,1,1,0,0,0,0, 32'h0,        1,0,0,0,0};
        tbl[3]  = '{0,0,0,0,1,1,0, 32'h0,        1,1,0,0,0};
        tbl[4]  = '{0,0,0,0,1,0,0, 32'h0,        1,2,0,0,0};
        tbl[5]  = '{0,0,1,0,0,0,0, 32'h0,        2,0,0,1,0};
        tbl[6]  = '{0,0,0,0,0,0,0, 32'h0,        2,0,0,0,0};
        tbl[7]  = '{0,0,0,0,0,0,1, 32'h80000001, 3,0,0,0,1};
        tbl[8]  = '{0,0,0,0,1,0,0, 32'h0,        3,1,0,0,1};
        tbl[9]  = '{0,0,0,1,0,0,0, 32'h0,        0,0,0,0,0};
        tbl[10] = '{0,0,0,0,0,0,1, 32'h12345678, 0,0,0,0,0};
        tbl[11] = '{0,0,1,0,0,0,0, 32'h0,        2,0,0,1,0};
        tbl[12] = '{0,0,0,0,0,0,1, 32'hFFFFFFFF, 2,0,0,0,0};
        tbl[13] = '{0,0,0,0,0,0,1, 32'h40000000, 3,0,0,0,1};
        tbl[14] = '{1,0,1,0,1,0,0, 32'h0,        0,0,0,0,0};
        tbl[15] = '{0,0,0,1,0,0,0, 32'h0,        0,0,0,0,0};

        cyc(1, 0, 0, 0, 0, 0, 0, '0);
        cyc(1, 0, 0, 0, 0, 0, 0, '0);
        check("rst_wr_data", wr_data, 0);
        check("rst_mode", mode, 0);

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].r, tbl[i].rb, tbl[i].pb, tbl[i].sb, tbl[i].be, tbl[i].bi, tbl[i].rv, tbl[i].d);
            check($sformatf("tbl%0d_mode", i), mode, tbl[i].mode);
            check($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
            check($sformatf("tbl%0d_wr_valid", i), wr_valid, tbl[i].wv);
            check($sformatf("tbl%0d_rd_req", i), rd_req, tbl[i].rq);
            check($sformatf("tbl%0d_bov", i), bit_out_valid, tbl[i].bov);
        end

        // Full word record
        w = 32'hA5A5F00F; wv_seen = 0;
        cyc(0, 1, 0, 0, 0, 0, 0, '0);
        for (int i = 31; i >= 0; i--) cyc(0, 0, 0, 0, 1, w[i], 0, '0);
        check("rec_wv", wr_valid, 1);
        check("rec_wr_data", wr_data, 32'hA5A5F00F);
        check("rec_count", count, 0);
        idle();
        check("rec_one_pulse", wv_seen, 1);
        check("rec_hold", wr_data, 32'hA5A5F00F);

        // Restart mid-word discards the partial bits
        w = 32'h12345678; wv_seen = 0;
        cyc(0, 1, 0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1, 1'($urandom), 0, '0);
        cyc(0, 1, 0, 0, 0, 0, 0, '0);
        for (int i = 31; i >= 0; i--) cyc(0, 0, 0, 0, 1, w[i], 0, '0);
        idle();
        check("restart_pulses", wv_seen, 1);
        check("restart_wr_data", wr_data, 32'h12345678);

        // Playback of one word, then underrun gap
        cyc(0, 0, 1, 0, 0, 0, 0, '0);
        check("play_rd_req", rd_req, 1);
        idle();
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h80000001);
        check("play_mode", mode, 3);
        got = '0;
        for (int i = 31; i >= 0; i--) begin
            check("play_bov", bit_out_valid, 1);
            got[i] = bit_out;
            cyc(0, 0, 0, 0, 1, 0, 0, '0);
        end
        check("play_bits", got, 32'h80000001);
        check("play_end_mode", mode, 2);
        check("play_end_rd_req", rd_req, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1, 0, 0, '0);
            check("gap_bov", bit_out_valid, 0);
            check("gap_rd_req", rd_req, 0);
        end

        // Rec beats play in the same cycle
        cyc(0, 1, 1, 0, 0, 0, 0, '0);
        check("prio_mode", mode, 1);
        check("prio_rd_req", rd_req, 0);

        // Stop with a 5-bit partial word
        cyc(0, 1, 0, 0, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, 1, 1, 0, '0);
        cyc(0, 0, 0, 0, 1, 0, 0, '0);
        cyc(0, 0, 0, 0, 1, 1, 0, '0);
        cyc(0, 0, 0, 0, 1, 1, 0, '0);
        cyc(0, 0, 0, 0, 1, 0, 0, '0);
        wd_before = wr_data; wv_seen = 0;
        cyc(0, 0, 0, 1, 0, 0, 0, '0);
`ifdef PACKET_SERDES_PARTIAL_FLUSH_EN
        check("flush_wv", wr_valid, 1);
        check("flush_data", wr_data, 32'hB0000000);
`else
        idle();
        check("discard_wv", wv_seen, 0);
        check("discard_data", wr_data, wd_before);
`endif
        check("stop_mode", mode, 0);

        // Reset in the middle of playback
        cyc(0, 0, 1, 0, 0, 0, 0, '0);
        idle();
        cyc(0, 0, 0, 0, 0, 0, 1, $urandom);
        for (int i = 0; i < 17; i++) cyc(0, 0, 0, 0, 1, 0, 0, '0);
        check("mid_count", count, 17);
        check("mid_mode", mode, 3);
        cyc(1, 1, 1, 0, 1, 1, 1, 32'hFFFFFFFF);
        check("rst_mode2", mode, 0);
        check("rst_count2", count, 0);
        check("rst_wr_data2", wr_data, 0);
        check("rst_wv2", wr_valid, 0);
        check("rst_rq2", rd_req, 0);
        check("rst_bov2", bit_out_valid, 0);
        check("rst_bo2", bit_out, 0);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 500) == 0, ($urandom % 150) == 0, ($urandom % 100) == 0,
                ($urandom % 200) == 0, ($urandom % 10) < 6, 1'($urandom),
                ($urandom % 4) == 0, $urandom);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
